memory_access: RTL and testbench

Pipeline stage directly downstream of execute. Takes the resolved instruction, its ALU result (used as the effective address) and rs2, and performs the load or store over a simple request/acknowledge data-memory port. Aligns and sign/zero-extends load data, and holds off upstream while an access is outstanding. Registered output feeds writeback; non-memory instructions pass through with one cycle of latency.

---
 rtl/memory_access.sv | 181 ++++++++++++++++++
 tb/tb_memory_access.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// Memory-access pipeline stage: performs loads/stores over a req/ack data port,
// aligns and extends load data, and registers the result toward writeback.
package memory_access_pkg;
  typedef enum logic [1:0] {
    MASK_BYTE = 2'd0,
    MASK_HALF = 2'd1,
    MASK_WORD = 2'd2
  } mem_mask_t;

  typedef struct packed {
    logic [1:0] reg_rd_src;
    logic       memory_read;
    logic       memory_write;
    mem_mask_t  memory_mask;
    logic       memory_sign;
  } instr_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  address;
    logic [31:0] data;
  } data_t;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] reg_rd1;
    logic [31:0] reg_rd2;
    instr_t      instr;
    data_t       data;
  } stage_status_t;
endpackage

module memory_access
  import memory_access_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  stage_status_t        stage_in,
  output stage_status_t        stage_out,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WIDTH-1:0]     mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic [WIDTH/8-1:0]   mem_wmask,
  input  logic [WIDTH-1:0]     mem_rdata,
  input  logic                 mem_ack,
  output logic                 misaligned
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state, state_next;
  logic          ready;
  stage_status_t out_r;
  stage_status_t pending;

  logic        accept, is_mem, misalign, start;
  logic [31:0] ea;
  logic [31:0] wdata_c;
  logic [3:0]  wmask_c;
  logic [31:0] shifted;
  logic [31:0] load_val;

  assign ea       = stage_in.data.data;
  assign accept   = stage_in.valid && ready;
  assign is_mem   = stage_in.instr.memory_read || stage_in.instr.memory_write;
  assign misalign = is_mem &&
                    (((stage_in.instr.memory_mask == MASK_HALF) && ea[0]) ||
                     ((stage_in.instr.memory_mask == MASK_WORD) && (ea[1:0] != 2'b00)));
  assign start    = accept && is_mem && !misalign;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)   state_next = BUSY;
      BUSY:    if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

  always_comb begin
    stage_out       = out_r;
    stage_out.ready = ready;
  end

  // Store lanes are replicated so the byte enables alone select the target bytes.
  always_comb begin
    wdata_c = stage_in.reg_rd2;
    wmask_c = 4'b1111;
    case (stage_in.instr.memory_mask)
      MASK_BYTE: begin
        wdata_c = {4{stage_in.reg_rd2[7:0]}};
        wmask_c = 4'b0001 << ea[1:0];
      end
      MASK_HALF: begin
        wdata_c = {2{stage_in.reg_rd2[15:0]}};
        wmask_c = 4'b0011 << ea[1:0];
      end
      default: begin
        wdata_c = stage_in.reg_rd2;
        wmask_c = 4'b1111;
      end
    endcase
  end

  always_comb begin
    shifted  = mem_rdata >> {pending.data.data[1:0], 3'b000};
    load_val = shifted;
    case (pending.instr.memory_mask)
      MASK_BYTE: load_val = {{24{pending.instr.memory_sign & shifted[7]}}, shifted[7:0]};
      MASK_HALF: load_val = {{16{pending.instr.memory_sign & shifted[15]}}, shifted[15:0]};
      default:   load_val = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_r      <= '0;
      pending    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      misaligned <= 1'b0;
    end else begin
      out_r.valid <= 1'b0;
      misaligned  <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (!is_mem) begin
            out_r       <= stage_in;
            out_r.valid <= 1'b1;
          end else if (misalign) begin
            out_r            <= stage_in;
            out_r.valid      <= 1'b1;
            out_r.data.valid <= 1'b0;
            misaligned       <= 1'b1;
          end else begin
            pending   <= stage_in;
            mem_req   <= 1'b1;
            mem_we    <= stage_in.instr.memory_write;
            mem_addr  <= {ea[31:2], 2'b00};
            mem_wdata <= wdata_c;
            mem_wmask <= stage_in.instr.memory_write ? wmask_c : 4'b0000;
          end
        end
      end else if (mem_ack) begin
        mem_req     <= 1'b0;
        mem_we      <= 1'b0;
        mem_wmask   <= '0;
        out_r       <= pending;
        out_r.valid <= 1'b1;
        if (pending.instr.memory_read && !pending.instr.memory_write) begin
          out_r.data.data  <= load_val;
          out_r.data.valid <= 1'b1;
        end else begin
          out_r.data.data  <= pending.data.data;
          out_r.data.valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: table of load/store/passthrough vectors plus
// hand-written reset and back-to-back sequences, outputs checked via a scoreboard.
module tb_memory_access;
  import memory_access_pkg::*;

  logic          clk;
  logic          rst;
  stage_status_t stage_in;
  stage_status_t stage_out;
  logic          mem_req, mem_we, mem_ack, misaligned;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_wmask;

  memory_access #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stage_in(stage_in), .stage_out(stage_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .misaligned(misaligned)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    mem_mask_t   mask;
    logic        sign;
    logic [31:0] ea;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int unsigned delay;
    logic [31:0] exp_data;
    logic        exp_dvalid;
    logic        exp_mis;
    logic        exp_req;
    logic        exp_we;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        dvalid;
  } exp_t;

  vec_t        vq[$];
  exp_t        scb[$];
  int unsigned out_cyc[$];
  int unsigned cycle = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stage_out.valid === 1'b1) begin
      out_cyc.push_back(cycle);
      if (scb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc %h want no output", stage_out.pc);
      end else begin
        mon_e = scb.pop_front();
        chk("out_pc", stage_out.pc, mon_e.pc);
        chk("out_rd", 32'(stage_out.data.address), 32'(mon_e.addr));
        chk("out_data", stage_out.data.data, mon_e.data);
        chk("out_dvalid", 32'(stage_out.data.valid), 32'(mon_e.dvalid));
      end
    end
  end

  task automatic add(input logic rd, input logic wr, input mem_mask_t mask, input logic sign,
                     input logic [31:0] ea, input logic [31:0] rs2, input logic [31:0] rdata,
                     input int unsigned delay, input logic [31:0] exp_data, input logic exp_dvalid,
                     input logic exp_mis, input logic exp_req, input logic exp_we,
                     input logic [3:0] exp_wmask, input logic [31:0] exp_wdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.mask = mask; v.sign = sign; v.ea = ea; v.rs2 = rs2;
    v.rdata = rdata; v.delay = delay; v.exp_data = exp_data; v.exp_dvalid = exp_dvalid;
    v.exp_mis = exp_mis; v.exp_req = exp_req; v.exp_we = exp_we;
    v.exp_wmask = exp_wmask; v.exp_wdata = exp_wdata;
    vq.push_back(v);
  endtask

  task automatic wait_ready();
    int unsigned n = 0;
    while (stage_out.ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (stage_out.ready !== 1'b1) chk("ready_wait", 32'(stage_out.ready), 32'd1);
  endtask

  task automatic drive(input logic rd, input logic wr, input mem_mask_t mask, input logic sign,
                       input logic [31:0] ea, input logic [31:0] rs2, input logic [31:0] pc,
                       input logic [4:0] rdaddr);
    stage_in                    = '0;
    stage_in.valid              = 1'b1;
    stage_in.pc                 = pc;
    stage_in.reg_rd1            = 32'h0BAD_0001;
    stage_in.reg_rd2            = rs2;
    stage_in.instr.reg_rd_src   = 2'd1;
    stage_in.instr.memory_read  = rd;
    stage_in.instr.memory_write = wr;
    stage_in.instr.memory_mask  = mask;
    stage_in.instr.memory_sign  = sign;
    stage_in.data.valid         = !(rd || wr);
    stage_in.data.address       = rdaddr;
    stage_in.data.data          = ea;
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    wait_ready();
    e.pc = 32'h1000 + 32'(idx) * 4;
    e.addr = 5'(idx + 1);
    e.data = v.exp_data;
    e.dvalid = v.exp_dvalid;
    drive(v.rd, v.wr, v.mask, v.sign, v.ea, v.rs2, e.pc, e.addr);
    scb.push_back(e);
    @(posedge clk); #1;
    stage_in.valid = 1'b0;
    chk($sformatf("v%0d_mis", idx), 32'(misaligned), 32'(v.exp_mis));
    chk($sformatf("v%0d_req", idx), 32'(mem_req), 32'(v.exp_req));
    if (v.exp_req) begin
      chk($sformatf("v%0d_we", idx), 32'(mem_we), 32'(v.exp_we));
      chk($sformatf("v%0d_wmask", idx), 32'(mem_wmask), 32'(v.exp_wmask));
      if (v.exp_we) chk($sformatf("v%0d_wdata", idx), mem_wdata, v.exp_wdata);
      chk($sformatf("v%0d_addr", idx), mem_addr, {v.ea[31:2], 2'b00});
      chk($sformatf("v%0d_busy_ready", idx), 32'(stage_out.ready), 32'd0);
      for (int unsigned d = 0; d < v.delay; d++) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d_wait_ready", idx), 32'(stage_out.ready), 32'd0);
        chk($sformatf("v%0d_wait_req", idx), 32'(mem_req), 32'd1);
      end
      mem_rdata = v.rdata;
      mem_ack   = 1'b1;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      chk($sformatf("v%0d_done_ready", idx), 32'(stage_out.ready), 32'd1);
      chk($sformatf("v%0d_done_req", idx), 32'(mem_req), 32'd0);
    end else begin
      chk($sformatf("v%0d_idle_ready", idx), 32'(stage_out.ready), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_mis_drop", idx), 32'(misaligned), 32'd0);
    end
  endtask

  initial begin
    exp_t e;
    stage_in  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    rst       = 1'b1;

    //  rd wr mask       sg ea            rs2           rdata         dly exp_data     dv mis req we wmask    wdata
    add(0, 0, MASK_WORD, 0, 32'h0000_1234, 32'h0,        32'h0,        0, 32'h0000_1234, 1, 0, 0, 0, 4'b0000, 32'h0);
    add(1, 0, MASK_BYTE, 1, 32'h0000_0103, 32'h0,        32'h80FF_FF00, 3, 32'hFFFF_FF80, 1, 0, 1, 0, 4'b0000, 32'h0);
    add(1, 0, MASK_BYTE, 0, 32'h0000_0103, 32'h0,        32'h80FF_FF00, 3, 32'h0000_0080, 1, 0, 1, 0, 4'b0000, 32'h0);
    add(0, 1, MASK_HALF, 0, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0,        0, 32'h0000_0202, 0, 0, 1, 1, 4'b1100, 32'hBEEF_BEEF);
    add(1, 0, MASK_WORD, 0, 32'h0000_0301, 32'h0,        32'h0,        0, 32'h0000_0301, 0, 1, 0, 0, 4'b0000, 32'h0);
    add(1, 0, MASK_HALF, 1, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 1, 32'hFFFF_8001, 1, 0, 1, 0, 4'b0000, 32'h0);
    add(1, 0, MASK_HALF, 0, 32'h0000_0000, 32'h0,        32'h1234_F00D, 0, 32'h0000_F00D, 1, 0, 1, 0, 4'b0000, 32'h0);
    add(0, 1, MASK_BYTE, 0, 32'h0000_0001, 32'h0000_0055, 32'h0,        2, 32'h0000_0001, 0, 0, 1, 1, 4'b0010, 32'h5555_5555);
    add(0, 1, MASK_WORD, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        0, 32'h0000_0010, 0, 0, 1, 1, 4'b1111, 32'hDEAD_BEEF);
    add(1, 0, MASK_WORD, 1, 32'h0000_0040, 32'h0,        32'hCAFE_BABE, 1, 32'hCAFE_BABE, 1, 0, 1, 0, 4'b0000, 32'h0);
    add(0, 1, MASK_HALF, 0, 32'h0000_0003, 32'h1111_2222, 32'h0,        0, 32'h0000_0003, 0, 1, 0, 0, 4'b0000, 32'h0);
    add(1, 0, MASK_BYTE, 1, 32'h0000_0001, 32'h0,        32'h0000_7F00, 0, 32'h0000_007F, 1, 0, 1, 0, 4'b0000, 32'h0);

    // Reset for two cycles with a stray ack in the middle.
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    rst = 1'b0;
    chk("rst_valid", 32'(stage_out.valid), 32'd0);
    chk("rst_dvalid", 32'(stage_out.data.valid), 32'd0);
    chk("rst_data", stage_out.data.data, 32'd0);
    chk("rst_pc", stage_out.pc, 32'd0);
    chk("rst_ready", 32'(stage_out.ready), 32'd1);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back word load then store, both acked on their first busy cycle.
    out_cyc.delete();
    add(1, 0, MASK_WORD, 0, 32'h0000_0080, 32'h0,        32'h0102_0304, 0, 32'h0102_0304, 1, 0, 1, 0, 4'b0000, 32'h0);
    add(0, 1, MASK_WORD, 0, 32'h0000_0084, 32'h5A5A_A5A5, 32'h0,        0, 32'h0000_0084, 0, 0, 1, 1, 4'b1111, 32'h5A5A_A5A5);
    apply(vq[vq.size()-2], 20);
    apply(vq[vq.size()-1], 21);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_count", 32'(out_cyc.size()), 32'd2);
    if (out_cyc.size() == 2) chk("b2b_spacing", out_cyc[1] - out_cyc[0], 32'd2);

    // An instruction held valid across the completing edge is taken one edge later.
    out_cyc.delete();
    drive(1, 0, MASK_WORD, 0, 32'h0000_0044, 32'h0, 32'h2000, 5'd7);
    e.pc = 32'h2000; e.addr = 5'd7; e.data = 32'h1111_2222; e.dvalid = 1'b1;
    scb.push_back(e);
    @(posedge clk); #1;
    drive(0, 0, MASK_WORD, 0, 32'h0000_0077, 32'h0, 32'h2004, 5'd9);
    e.pc = 32'h2004; e.addr = 5'd9; e.data = 32'h0000_0077; e.dvalid = 1'b1;
    scb.push_back(e);
    mem_rdata = 32'h1111_2222;
    mem_ack   = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("hold_ready", 32'(stage_out.ready), 32'd1);
    @(posedge clk); #1;
    stage_in.valid = 1'b0;
    chk("hold_req", 32'(mem_req), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_count", 32'(out_cyc.size()), 32'd2);
    if (out_cyc.size() == 2) chk("hold_spacing", out_cyc[1] - out_cyc[0], 32'd1);

    // Reset while busy abandons the access; a late ack is ignored.
    drive(1, 0, MASK_WORD, 0, 32'h0000_0090, 32'h0, 32'h3000, 5'd3);
    @(posedge clk); #1;
    stage_in.valid = 1'b0;
    chk("rb_req_pre", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rb_req", 32'(mem_req), 32'd0);
    chk("rb_ready", 32'(stage_out.ready), 32'd1);
    mem_rdata = 32'hFFFF_FFFF;
    mem_ack   = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_ready", 32'(stage_out.ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("scb_drain", 32'(scb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
